// File: rtl/banked_mem_ctrl_if.sv
// Bus bundle between the datapath, banked_mem_ctrl and the memory array.
//   Datapath side : req, we, addr, wdata -> controller; rdata, ack, fault, busy <- controller
//   Memory side   : mem_cs, rom_cs, mem_addr, mem_we, mem_oe, mem_wdata <- controller
//                   bank_rdata (bank0 in the LSBs), rom_rdata -> controller
// Modports: slave = the controller, master = datapath plus memory model.
interface banked_mem_if #(
    parameter int DATA_WIDTH      = 64,
    parameter int ADDR_WIDTH      = 32,
    parameter int BANK_ADDR_WIDTH = 12,
    parameter int NUM_BANKS       = 4
);
    logic                            req;
    logic                            we;
    logic [ADDR_WIDTH-1:0]           addr;
    logic [DATA_WIDTH-1:0]           wdata;
    logic [DATA_WIDTH-1:0]           rdata;
    logic                            ack;
    logic                            fault;
    logic                            busy;
    logic [NUM_BANKS-1:0]            mem_cs;
    logic                            rom_cs;
    logic [BANK_ADDR_WIDTH-1:0]      mem_addr;
    logic                            mem_we;
    logic                            mem_oe;
    logic [DATA_WIDTH-1:0]           mem_wdata;
    logic [NUM_BANKS*DATA_WIDTH-1:0] bank_rdata;
    logic [DATA_WIDTH-1:0]           rom_rdata;

    modport slave (
        input  req, we, addr, wdata, bank_rdata, rom_rdata,
        output rdata, ack, fault, busy, mem_cs, rom_cs, mem_addr, mem_we, mem_oe, mem_wdata
    );

    modport master (
        output req, we, addr, wdata, bank_rdata, rom_rdata,
        input  rdata, ack, fault, busy, mem_cs, rom_cs, mem_addr, mem_we, mem_oe, mem_wdata
    );
endinterface

// File: rtl/banked_mem_ctrl.sv
// Memory-bus controller: decodes an address into one read-only ROM region and
// NUM_BANKS RAM banks, runs each access through ACCESS / WAIT / DONE with
// WAIT_STATES extra cycles, and reports completion with a one-cycle ack.
// Unmapped addresses and ROM writes complete immediately with fault=1 and
// never touch a select or strobe.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - asynchronous reset, active-low
//   bus  - banked_mem_if.slave: datapath handshake and memory-side signals
module banked_mem_ctrl #(
    parameter int DATA_WIDTH      = 64,
    parameter int ADDR_WIDTH      = 32,
    parameter int BANK_ADDR_WIDTH = 12,
    parameter int NUM_BANKS       = 4,
    parameter int WAIT_STATES     = 1
) (
    input logic         clk,
    input logic         rst,
    banked_mem_if.slave bus
);
    localparam int         SEL_W  = $clog2(NUM_BANKS + 1);
    localparam int         HI_LSB = BANK_ADDR_WIDTH + SEL_W;
    localparam logic [3:0] WS     = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

    state_t                     state;
    state_t                     state_nxt;

    logic [BANK_ADDR_WIDTH-1:0] off;
    logic [SEL_W-1:0]           sel;
    logic [SEL_W-1:0]           bank_idx;
    logic                       unmapped;
    logic                       is_rom;
    logic                       dec_fault;
    logic [NUM_BANKS-1:0]       dec_cs;

    logic                       we_q;
    logic                       rom_q;
    logic                       fault_q;
    logic [NUM_BANKS-1:0]       cs_q;
    logic [SEL_W-1:0]           bank_q;
    logic [BANK_ADDR_WIDTH-1:0] off_q;
    logic [DATA_WIDTH-1:0]      wdata_q;
    logic [DATA_WIDTH-1:0]      rdata_q;
    logic [3:0]                 cnt_q;

    logic                       accept;
    logic                       active;
    logic                       last_cyc;
    logic [DATA_WIDTH-1:0]      src_data;

    // Address decode: region select above the word offset; anything past the
    // last bank, or with stray high bits, is unmapped.
    assign off       = bus.addr[BANK_ADDR_WIDTH-1:0];
    assign sel       = bus.addr[BANK_ADDR_WIDTH +: SEL_W];
    assign unmapped  = ({1'b0, sel} > (SEL_W+1)'(NUM_BANKS)) ||
                       ((bus.addr >> HI_LSB) != '0);
    assign is_rom    = (sel == '0);
    assign dec_fault = unmapped || (is_rom && bus.we);
    assign bank_idx  = sel - SEL_W'(1);

    always_comb begin
        dec_cs = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (!dec_fault && (sel == SEL_W'(i + 1))) dec_cs[i] = 1'b1;
        end
    end

    assign accept   = (state == S_IDLE) && bus.req;
    assign active   = (state == S_ACCESS) || (state == S_WAIT);
    // Data is captured on the cycle that hands over to DONE.
    assign last_cyc = ((state == S_ACCESS) && (WS == 4'd0)) ||
                      ((state == S_WAIT) && (cnt_q == 4'd1));

    always_comb begin
        src_data = bus.rom_rdata;
        if (!rom_q) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                if (bank_q == SEL_W'(i)) src_data = bus.bank_rdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.req) state_nxt = dec_fault ? S_DONE : S_ACCESS;
            S_ACCESS: state_nxt = (WS == 4'd0) ? S_DONE : S_WAIT;
            S_WAIT:   if (cnt_q == 4'd1) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Request latch, wait counter and read-data capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            rom_q   <= 1'b0;
            fault_q <= 1'b0;
            cs_q    <= '0;
            bank_q  <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                we_q    <= bus.we;
                rom_q   <= is_rom && !dec_fault;
                fault_q <= dec_fault;
                cs_q    <= dec_cs;
                bank_q  <= bank_idx;
                off_q   <= off;
                wdata_q <= bus.wdata;
                cnt_q   <= WS;
            end else if (state == S_WAIT) begin
                cnt_q   <= cnt_q - 4'd1;
            end
            if (last_cyc && !we_q) rdata_q <= src_data;
        end
    end

    assign bus.mem_cs    = active ? cs_q : '0;
    assign bus.rom_cs    = active && rom_q;
    assign bus.mem_we    = (state == S_ACCESS) && we_q;
    assign bus.mem_oe    = active && !we_q;
    assign bus.mem_addr  = off_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.ack       = (state == S_DONE);
    assign bus.fault     = (state == S_DONE) && fault_q;
    assign bus.busy      = (state != S_IDLE);
    assign bus.rdata     = rdata_q;
endmodule

// File: tb/tb_banked_mem_ctrl.sv
`timescale 1ns/1ps
module tb_banked_mem_ctrl;
    localparam int DW  = 64;
    localparam int AW  = 32;
    localparam int BAW = 12;
    localparam int NB  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    banked_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BANK_ADDR_WIDTH(BAW), .NUM_BANKS(NB)) bus1 ();
    banked_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BANK_ADDR_WIDTH(BAW), .NUM_BANKS(NB)) bus0 ();
    banked_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BANK_ADDR_WIDTH(BAW), .NUM_BANKS(NB)) bus3 ();

    banked_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BANK_ADDR_WIDTH(BAW), .NUM_BANKS(NB),
                      .WAIT_STATES(1)) u_dut (.clk(clk), .rst(rst), .bus(bus1));
    banked_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BANK_ADDR_WIDTH(BAW), .NUM_BANKS(NB),
                      .WAIT_STATES(0)) u_w0 (.clk(clk), .rst(rst), .bus(bus0));
    banked_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BANK_ADDR_WIDTH(BAW), .NUM_BANKS(NB),
                      .WAIT_STATES(3)) u_w3 (.clk(clk), .rst(rst), .bus(bus3));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] fpat(input int b, input int o);
        return {32'(b + 1), 32'(o) * 32'h9E37_79B9};
    endfunction

    // Memory array behind the main controller.
    logic [DW-1:0] ram [NB][4096];
    initial begin
        for (int b = 0; b < NB; b++)
            for (int o = 0; o < 4096; o++) ram[b][o] = fpat(b, o);
        forever begin
            @(posedge clk);
            for (int b = 0; b < NB; b++)
                if (bus1.mem_we && bus1.mem_cs[b]) ram[b][bus1.mem_addr] = bus1.mem_wdata;
        end
    end
    always_comb begin
        for (int b = 0; b < NB; b++) bus1.bank_rdata[b*DW +: DW] = ram[b][bus1.mem_addr];
    end
    assign bus1.rom_rdata = 64'h1224 + 64'(bus1.mem_addr);

    assign bus0.bank_rdata = {64'hB3, 64'hB2, 64'hB1, 64'hC0DE_0000_0000_00B0};
    assign bus0.rom_rdata  = 64'h0;
    assign bus3.bank_rdata = {64'hB3, 64'hB2, 64'hB1, 64'hC0DE_0000_0000_03B0};
    assign bus3.rom_rdata  = 64'h0;

    // Reference model of the WAIT_STATES=1 controller: an accepted access
    // occupies cycles 1..lat counted from the sample edge, with selects on
    // cycles 1..lat-1 and ack on cycle lat.
    logic [63:0] ref_ram [NB][4096];
    initial begin : model
        int          phase;
        int          lat;
        int          bank;
        int          region;
        logic        m_we;
        logic        m_rom;
        logic        m_fault;
        logic        act;
        logic [11:0] m_off;
        logic [63:0] m_wdata;
        logic [63:0] m_rd;
        logic [63:0] m_next_rd;
        phase = 0; lat = 1; bank = 0; region = 0;
        m_we = 0; m_rom = 0; m_fault = 0; m_off = '0;
        m_wdata = '0; m_rd = '0; m_next_rd = '0;
        for (int b = 0; b < NB; b++)
            for (int o = 0; o < 4096; o++) ref_ram[b][o] = fpat(b, o);
        forever begin
            @(negedge clk);
            if (!rst) begin
                phase = 0;
                m_rd  = '0;
                chk("rst_busy", 64'(bus1.busy), 64'd0);
                chk("rst_ack", 64'(bus1.ack), 64'd0);
                chk("rst_cs", 64'({bus1.mem_cs, bus1.rom_cs, bus1.mem_we, bus1.mem_oe}), 64'd0);
                chk("rst_rdata", bus1.rdata, 64'd0);
            end else begin
                act = (phase >= 1) && (phase < lat) && !m_fault;
                chk("busy", 64'(bus1.busy), 64'(phase != 0));
                chk("ack", 64'(bus1.ack), 64'(phase != 0 && phase == lat));
                chk("fault", 64'(bus1.fault), 64'(phase != 0 && phase == lat && m_fault));
                chk("mem_cs", 64'(bus1.mem_cs), (act && !m_rom) ? (64'd1 << bank) : 64'd0);
                chk("rom_cs", 64'(bus1.rom_cs), 64'(act && m_rom));
                chk("mem_we", 64'(bus1.mem_we), 64'(act && m_we && phase == 1));
                chk("mem_oe", 64'(bus1.mem_oe), 64'(act && !m_we));
                if (act) chk("mem_addr", 64'(bus1.mem_addr), 64'(m_off));
                if (act && m_we && phase == 1) chk("mem_wdata", bus1.mem_wdata, m_wdata);
                chk("rdata", bus1.rdata, m_rd);
                if (phase != 0) begin
                    if (phase == lat) phase = 0;
                    else begin
                        phase++;
                        if (phase == lat && !m_fault && !m_we) m_rd = m_next_rd;
                    end
                end else if (bus1.req) begin
                    region  = int'(bus1.addr >> BAW);
                    m_we    = bus1.we;
                    m_off   = bus1.addr[11:0];
                    m_wdata = bus1.wdata;
                    m_rom   = (region == 0);
                    m_fault = (region > NB) || (m_rom && m_we);
                    bank    = m_rom ? 0 : region - 1;
                    lat     = m_fault ? 1 : 3;
                    phase   = 1;
                    if (!m_fault) begin
                        if (m_we) ref_ram[bank][m_off] = m_wdata;
                        else      m_next_rd = m_rom ? 64'h1224 + 64'(m_off) : ref_ram[bank][m_off];
                    end
                end
            end
        end
    end

    task automatic do_access(input logic w, input logic [31:0] a, input logic [63:0] d,
                             output int ack_cyc, output logic flt, output int we_cnt,
                             output int oe_cnt, output logic [3:0] cs_seen, output logic rom_seen);
        ack_cyc = 0; flt = 0; we_cnt = 0; oe_cnt = 0; cs_seen = '0; rom_seen = 0;
        bus1.req = 1'b1; bus1.we = w; bus1.addr = a; bus1.wdata = d;
        @(posedge clk); #1 bus1.req = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus1.mem_we) we_cnt++;
            if (bus1.mem_oe) oe_cnt++;
            cs_seen  = cs_seen | bus1.mem_cs;
            rom_seen = rom_seen | bus1.rom_cs;
            if (bus1.ack) begin
                ack_cyc = n;
                flt     = bus1.fault;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    // Read of bank0 on the W=0 (which=0) or W=3 (which=1) controller; req is
    // held for 'hold' extra cycles while the access is in flight.
    task automatic lat_read(input int which, input int hold, output int ack_cyc,
                            output int acks, output int busy_cnt, output logic [63:0] rd);
        ack_cyc = 0; acks = 0; busy_cnt = 0; rd = '0;
        if (which == 0) begin bus0.req = 1'b1; bus0.we = 1'b0; bus0.addr = 32'h1000; end
        else            begin bus3.req = 1'b1; bus3.we = 1'b0; bus3.addr = 32'h1000; end
        @(posedge clk); #1;
        for (int n = 1; n <= 12; n++) begin
            if (n > hold) begin
                if (which == 0) bus0.req = 1'b0;
                else            bus3.req = 1'b0;
            end
            @(negedge clk);
            if ((which == 0) ? bus0.busy : bus3.busy) busy_cnt++;
            if ((which == 0) ? bus0.ack : bus3.ack) begin
                acks++;
                if (ack_cyc == 0) begin
                    ack_cyc = n;
                    rd = (which == 0) ? bus0.rdata : bus3.rdata;
                end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int          ac;
        logic        fl;
        int          wc;
        int          oc;
        logic [3:0]  cs;
        logic        rs;
        int          acks;
        int          bc;
        logic [63:0] rd;
        int          n;
        int          region;
        logic [31:0] a;
        logic        hold;
        bus1.req = 0; bus1.we = 0; bus1.addr = '0; bus1.wdata = '0;
        bus0.req = 0; bus0.we = 0; bus0.addr = '0; bus0.wdata = '0;
        bus3.req = 0; bus3.we = 0; bus3.addr = '0; bus3.wdata = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdata", bus1.rdata, 64'd0);
        chk("reset_busy", 64'(bus1.busy), 64'd0);
        chk("reset_mem_addr", 64'(bus1.mem_addr), 64'd0);
        chk("reset_mem_wdata", bus1.mem_wdata, 64'd0);
        chk("reset_strobes", 64'({bus1.mem_cs, bus1.rom_cs, bus1.mem_we, bus1.mem_oe, bus1.ack, bus1.fault}), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        do_access(1'b1, 32'h0000_1005, 64'hDEAD_BEEF_0123_4567, ac, fl, wc, oc, cs, rs);
        chk("wr_ack_cycle", 64'(ac), 64'd3);
        chk("wr_fault", 64'(fl), 64'd0);
        chk("wr_we_cycles", 64'(wc), 64'd1);
        chk("wr_cs", 64'(cs), 64'b0001);

        do_access(1'b0, 32'h0000_1005, 64'h0, ac, fl, wc, oc, cs, rs);
        chk("rd_ack_cycle", 64'(ac), 64'd3);
        chk("rd_oe_cycles", 64'(oc), 64'd2);
        chk("rd_data", bus1.rdata, 64'hDEAD_BEEF_0123_4567);

        do_access(1'b0, 32'h0000_0010, 64'h0, ac, fl, wc, oc, cs, rs);
        chk("rom_rd_cs", 64'({rs, cs}), 64'b1_0000);
        chk("rom_rd_data", bus1.rdata, 64'h1234);

        do_access(1'b1, 32'h0000_0010, 64'h55, ac, fl, wc, oc, cs, rs);
        chk("rom_wr_ack_cycle", 64'(ac), 64'd1);
        chk("rom_wr_fault", 64'(fl), 64'd1);
        chk("rom_wr_strobes", 64'({rs, cs, 4'(wc), 4'(oc)}), 64'd0);

        do_access(1'b0, 32'h0000_5000, 64'h0, ac, fl, wc, oc, cs, rs);
        chk("unmap_sel_fault", 64'(fl), 64'd1);
        chk("unmap_sel_cs", 64'({rs, cs, 4'(oc)}), 64'd0);
        chk("unmap_sel_rdata", bus1.rdata, 64'h1234);
        do_access(1'b0, 32'h0100_1000, 64'h0, ac, fl, wc, oc, cs, rs);
        chk("unmap_hi_fault", 64'(fl), 64'd1);
        chk("unmap_hi_cs", 64'({rs, cs, 4'(oc)}), 64'd0);
        chk("unmap_hi_rdata", bus1.rdata, 64'h1234);

        lat_read(0, 0, ac, acks, bc, rd);
        chk("w0_ack_cycle", 64'(ac), 64'd2);
        chk("w0_acks", 64'(acks), 64'd1);
        chk("w0_rdata", rd, 64'hC0DE_0000_0000_00B0);
        lat_read(1, 2, ac, acks, bc, rd);
        chk("w3_ack_cycle", 64'(ac), 64'd5);
        chk("w3_acks", 64'(acks), 64'd1);
        chk("w3_busy_cycles", 64'(bc), 64'd5);
        chk("w3_rdata", rd, 64'hC0DE_0000_0000_03B0);

        bus1.req = 1'b1; bus1.we = 1'b0; bus1.addr = 32'h0000_1005;
        @(posedge clk); #1 bus1.req = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_oe", 64'(bus1.mem_oe), 64'd1);
        rst = 1'b0;
        #1;
        chk("abort_outputs", 64'({bus1.busy, bus1.ack, bus1.mem_cs, bus1.rom_cs, bus1.mem_oe, bus1.mem_we}), 64'd0);
        chk("abort_rdata", bus1.rdata, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        do_access(1'b0, 32'h0000_1005, 64'h0, ac, fl, wc, oc, cs, rs);
        chk("post_rst_ack_cycle", 64'(ac), 64'd3);
        chk("post_rst_rdata", bus1.rdata, 64'hDEAD_BEEF_0123_4567);

        for (int t = 0; t < 250; t++) begin
            region = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 7));
            a = (32'(region) << BAW) | 32'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) a[$urandom_range(15, 31)] = 1'b1;
            bus1.we    = 1'($urandom_range(0, 1));
            bus1.addr  = a;
            bus1.wdata = {$urandom, $urandom};
            bus1.req   = 1'b1;
            hold       = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
            if (hold) begin
                @(posedge clk); #1;
            end
            bus1.req = 1'b0;
            n = 0;
            while (bus1.busy && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            chk("rand_done", 64'(bus1.busy), 64'd0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
